instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the instruction store size in 32-bit words (power of 2, 2..256).
REQ-002 SHALL have parameter AW, default 6, meaning the word-index width, equal to log2(DEPTH).
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the sentinel instruction that ends a program.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-006 SHALL have port load_en, input, 1, a write strobe for the instruction store.
REQ-007 SHALL have port load_addr, input, AW, the word index written when load_en=1.
REQ-008 SHALL have port load_data, input, 32, the instruction word written when load_en=1.
REQ-009 SHALL have port start, input, 1, a single-cycle request to begin issuing from word 0.
REQ-010 SHALL have port instr_out, output, 32, the issued instruction, feeding the processor instruction input.
REQ-011 SHALL have port instr_valid, output, 1, meaning instr_out holds a valid instruction.
REQ-012 SHALL have port instr_ready, input, 1, meaning the processor accepts instr_out this cycle.
REQ-013 SHALL have port pc, output, AW+2, the byte address of the current word, always word-aligned with pc[1:0]=0.
REQ-014 SHALL have port busy, output, 1, high in states FETCH and ISSUE.
REQ-015 SHALL have port done, output, 1, high in state DONE.

Function
REQ-016 SHALL hold the instructions in a DEPTH x 32 store with a synchronous read of one-cycle latency.
REQ-017 SHALL implement the states IDLE, FETCH, ISSUE and DONE.
REQ-018 SHALL, in IDLE or DONE with load_en=1, write load_data to load_data's word index load_addr at the clock edge.
REQ-019 SHALL ignore load_en while busy=1, leaving the store unchanged.
REQ-020 SHALL, in IDLE or DONE with start=1 and load_en=0, set pc to 0 and enter FETCH.
REQ-021 SHALL, when start=1 and load_en=1 in the same cycle, perform the load and ignore start.
REQ-022 SHALL, in FETCH, read word pc[AW+1:2] and move to ISSUE on the next edge, so the first instr_valid is asserted 2 cycles after start is sampled.
REQ-023 SHALL, on entering ISSUE with a fetched word equal to HALT_WORD, go directly to DONE without asserting instr_valid.
REQ-024 SHALL, in ISSUE, assert instr_valid=1 and hold instr_out and pc stable until instr_ready=1.
REQ-025 SHALL treat a cycle with instr_valid=1 and instr_ready=1 as one transfer, and SHALL never drop or duplicate a word.
REQ-026 SHALL, on a transfer at word index DEPTH-1, enter DONE with pc unchanged; pc SHALL NOT wrap to 0.
REQ-027 SHALL, on any other transfer, set pc to pc+4 and enter FETCH, so transfers occur at most every 2 cycles.
REQ-028 SHALL ignore a start asserted while busy=1.
REQ-029 SHALL keep instr_valid low in IDLE, FETCH and DONE.
REQ-030 SHALL keep done=1 in DONE until either a start is accepted or reset is asserted.
REQ-031 SHALL NOT combinationally depend instr_valid on instr_ready.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, set the state to IDLE, pc=0, instr_out=0, instr_valid=0, busy=0 and done=0.
REQ-033 SHALL give reset priority over load_en, start and instr_ready, including when reset occurs mid-ISSUE, in which case the pending word is discarded.
REQ-034 SHALL NOT clear the instruction store on reset.

Verification
REQ-035 SHALL cover this case: load words 0..2 = 0x20010005, 0x00221820, HALT_WORD, pulse start, hold instr_ready=1 -> 0x20010005 is issued at pc=0 two cycles after start, then 0x00221820 at pc=4, then done=1 with no third valid.
REQ-036 SHALL cover this case: backpressure with instr_ready=0 for 5 cycles during ISSUE -> instr_valid, instr_out and pc stay constant, and exactly one transfer occurs when instr_ready rises.
REQ-037 SHALL cover this case: fill all DEPTH words with non-halt values and run -> 64 transfers occur, pc ends at 0xFC, done=1, and no wrap occurs.
REQ-038 SHALL cover this case: assert reset on a cycle with instr_valid=1 -> on the next cycle instr_valid=0, pc=0 and state IDLE, and the store contents are readable unchanged on a restart.
REQ-039 SHALL cover this case: load_en while busy, and start together with load_en in IDLE -> the store is unchanged in the first case and the write happens with start ignored in the second.
REQ-040 SHALL cover this case: pulse start in DONE -> done falls and the program is reissued from pc=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a loadable DEPTH x 32 instruction store that issues words to a
// processor over a valid/ready handshake, starting at word 0 and stopping at HALT_WORD or the last word.
module instr_fetch #(
  parameter int unsigned   DEPTH     = 64,
  parameter int unsigned   AW        = 6,
  parameter logic [31:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW+1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   instr_q;
  logic [31:0]   mem [DEPTH];

  logic cmd_ok, load_ok, start_ok, is_halt, last_word;

  assign cmd_ok    = (state_q == IDLE) || (state_q == DONE);
  assign load_ok   = cmd_ok && load_en;
  assign start_ok  = cmd_ok && start && !load_en;
  assign is_halt   = (instr_q == HALT_WORD);
  assign last_word = (idx_q == AW'(DEPTH - 1));

  // NOTE: every variable is given its default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (is_halt) begin
          state_d = DONE;
        end else if (instr_ready) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == FETCH) instr_q <= mem[idx_q];
    end
  end

  // NOTE: the store has no reset on purpose; a program survives reset and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_addr] <= load_data;
  end

  // A fetched halt word spends its one ISSUE cycle invisible to the processor.
  assign instr_valid = (state_q == ISSUE) && !is_halt;
  assign instr_out   = instr_q;
  assign pc          = {idx_q, 2'b00};
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign done        = (state_q == DONE);

endmodule
